// File: rtl/ro_meter_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter.
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Ceiling log2 with a floor of 1, so a single channel still gets a 1-bit select.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    int unsigned v;
    w = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v != 0) begin
      w++;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ro_freq_meter_if.sv
// Control / readout bundle between the meter and its host.
interface ro_freq_meter_if
  import ro_meter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 15,
  parameter int unsigned GATE_W = 16
) ();

  localparam int unsigned CH_W = clog2(NUM_CH);

  logic              start;
  logic              abort;
  logic              continuous;
  logic [GATE_W-1:0] gate_cycles;
  logic [CH_W-1:0]   ch_sel;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  result;
  logic              overflow;

  modport master (
    output start, abort, continuous, gate_cycles, ch_sel,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, abort, continuous, gate_cycles, ch_sel,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/osc_edge_sync.sv
// Synchronises one asynchronous oscillator into clk and emits a 1-cycle
// pulse per rising edge. Free-running; only reset clears it.
module osc_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic osc,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_d;

  // Synchroniser chain followed by one delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], osc};
      s_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~s_d;

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronised rising
// edges per channel over a programmable gate window and latches the counts,
// with saturation flags, into a readout bank.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 15,
  parameter int unsigned GATE_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] osc_in,
  ro_freq_meter_if.slave    bus
);

  localparam int unsigned CH_W = clog2(NUM_CH);

  state_t            state;
  state_t            state_nxt;
  logic [GATE_W-1:0] gate_len;
  logic [GATE_W-1:0] gate_cnt;
  logic              gate_last;
  logic              bank_we;
  logic [NUM_CH-1:0] rise;

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt  [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] ovf_nxt;
  logic [CNT_W-1:0]  bank     [NUM_CH];
  logic [NUM_CH-1:0] bank_ovf;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    osc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .osc  (osc_in[g]),
      .rise (rise[g])
    );
  end

  assign gate_last = (gate_cnt == gate_len - GATE_W'(1));
  // The bank is written on the edge that closes the last GATE cycle, using the
  // counter next-values, so done (LATCH state) and the new bank appear together.
  assign bank_we   = (state == GATE) && gate_last && !bus.abort;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort dominates start and every in-flight state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start && !bus.abort) state_nxt = ARM;
      ARM:     state_nxt = bus.abort ? IDLE : GATE;
      GATE:    if (bus.abort)      state_nxt = IDLE;
               else if (gate_last) state_nxt = LATCH;
      LATCH:   state_nxt = (bus.abort || !bus.continuous) ? IDLE : ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // Window length capture on accepted start, and the gate cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_len <= '0;
      gate_cnt <= '0;
    end else begin
      if (state == IDLE && bus.start && !bus.abort)
        gate_len <= (bus.gate_cycles == '0) ? GATE_W'(1) : bus.gate_cycles;
      if (state == ARM)       gate_cnt <= '0;
      else if (state == GATE) gate_cnt <= gate_cnt + GATE_W'(1);
    end
  end

  // Per-channel saturating increment; ovf marks an edge lost at full scale.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = cnt[i];
      ovf_nxt[i] = ovf[i];
      if (rise[i]) begin
        if (cnt[i] == '1) ovf_nxt[i] = 1'b1;
        else              cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Edge counters: cleared in ARM, advance only during GATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (state == ARM) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (state == GATE) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
      ovf <= ovf_nxt;
    end
  end

  // Result bank: holds until the next completed window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) bank[i] <= '0;
      bank_ovf <= '0;
    end else if (bank_we) begin
      for (int unsigned i = 0; i < NUM_CH; i++) bank[i] <= cnt_nxt[i];
      bank_ovf <= ovf_nxt;
    end
  end

  // Readout mux; selects beyond the last channel read as zero.
  always_comb begin
    bus.result   = '0;
    bus.overflow = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.ch_sel == CH_W'(i)) begin
        bus.result   = bank[i];
        bus.overflow = bank_ovf[i];
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == LATCH);

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 4-channel instance with clk/4, clk/6,
// clk/8 and idle inputs, and a 1-channel 4-bit instance for saturation.
module tb_ro_freq_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o4 = 1'b0, o6 = 1'b0, o8 = 1'b0, o25 = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #10 clk = ~clk;                           // period 20
  initial begin #7;  forever begin o4  = ~o4;  #40; end end   // clk/4
  initial begin #13; forever begin o6  = ~o6;  #60; end end   // clk/6
  initial begin #17; forever begin o8  = ~o8;  #80; end end   // clk/8
  initial begin #3;  forever begin o25 = ~o25; #25; end end   // clk/2.5

  ro_freq_meter_if #(.NUM_CH(4), .CNT_W(15), .GATE_W(16)) bus  ();
  ro_freq_meter_if #(.NUM_CH(1), .CNT_W(4),  .GATE_W(16)) bus4 ();

  ro_freq_meter #(.NUM_CH(4), .CNT_W(15), .GATE_W(16), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .osc_in ({1'b0, o8, o6, o4}),
    .bus    (bus)
  );

  ro_freq_meter #(.NUM_CH(1), .CNT_W(4), .GATE_W(16), .SYNC_STAGES(3)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .osc_in (o25),
    .bus    (bus4)
  );

  // Called at a negedge; start is sampled at the next posedge (edge 0).
  task automatic pulse_start(input bit sel4, input logic [15:0] g);
    if (sel4) begin bus4.gate_cycles = g; bus4.start = 1'b1; end
    else      begin bus.gate_cycles  = g; bus.start  = 1'b1; end
    @(posedge clk); @(negedge clk);
    bus.start  = 1'b0;
    bus4.start = 1'b0;
  endtask

  // Counts posedges until done is seen; n = 0 on timeout.
  task automatic wait_done(input bit sel4, input int budget, output int n);
    n = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); @(negedge clk);
      if ((sel4 ? bus4.done : bus.done) === 1'b1) begin n = k; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      bus.ch_sel = c[1:0]; #1;
      n_checks++;
      if (bus.result !== 15'd0 || bus.overflow !== 1'b0)
        $display("FAIL reset_bank ch%0d got %0d/%b want 0/0", c, bus.result, bus.overflow);
      else n_pass++;
    end
    n_checks++; if (bus4.busy !== 1'b0 || bus4.result !== 4'd0)
      $display("FAIL reset_dut4 got busy=%b res=%0d want 0/0", bus4.busy, bus4.result); else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    int exp_v [4] = '{30, 20, 15, 0};
    pulse_start(1'b0, 16'd120);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy got %b want 1", bus.busy); else n_pass++;
    wait_done(1'b0, 200, n);
    n_checks++; if (n !== 121) $display("FAIL basic_latency got %0d want 121", n); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      bus.ch_sel = c[1:0]; #1;
      n_checks++;
      if ($isunknown(bus.result) || int'(bus.result) < exp_v[c] - 1 || int'(bus.result) > exp_v[c] + 1)
        $display("FAIL basic_result ch%0d got %0d want %0d+-1", c, bus.result, exp_v[c]);
      else n_pass++;
      n_checks++;
      if (bus.overflow !== 1'b0) $display("FAIL basic_ovf ch%0d got %b want 0", c, bus.overflow); else n_pass++;
    end
    bus.ch_sel = 2'd0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int n;
    bus4.ch_sel = 1'b0;
    pulse_start(1'b1, 16'd100);
    wait_done(1'b1, 150, n);
    n_checks++; if (n !== 101) $display("FAIL sat_latency got %0d want 101", n); else n_pass++;
    n_checks++; if (bus4.result !== 4'd15) $display("FAIL sat_result got %0d want 15", bus4.result); else n_pass++;
    n_checks++; if (bus4.overflow !== 1'b1) $display("FAIL sat_ovf got %b want 1", bus4.overflow); else n_pass++;
    bus4.ch_sel = 1'b1; #1;
    n_checks++; if (bus4.result !== 4'd0 || bus4.overflow !== 1'b0)
      $display("FAIL sel_out_of_range got %0d/%b want 0/0", bus4.result, bus4.overflow); else n_pass++;
    bus4.ch_sel = 1'b0;
    @(negedge clk);
    pulse_start(1'b1, 16'd10);
    wait_done(1'b1, 30, n);
    n_checks++; if (n !== 11) $display("FAIL sat2_latency got %0d want 11", n); else n_pass++;
    n_checks++; if ($isunknown(bus4.result) || bus4.result < 4'd3 || bus4.result > 4'd5)
      $display("FAIL sat2_result got %0d want 4+-1", bus4.result); else n_pass++;
    n_checks++; if (bus4.overflow !== 1'b0) $display("FAIL sat2_ovf got %b want 0", bus4.overflow); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_gate_zero();
    int n;
    pulse_start(1'b0, 16'd0);
    wait_done(1'b0, 10, n);
    n_checks++; if (n !== 2) $display("FAIL gate0_latency got %0d want 2", n); else n_pass++;
    n_checks++; if ($isunknown(bus.result) || bus.result > 15'd1)
      $display("FAIL gate0_result got %0d want 0..1", bus.result); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL gate0_idle got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_continuous();
    int n;
    bus.continuous = 1'b1;
    pulse_start(1'b0, 16'd40);
    wait_done(1'b0, 60, n);
    n_checks++; if (n !== 41) $display("FAIL cont_first got %0d want 41", n); else n_pass++;
    for (int w = 0; w < 2; w++) begin
      wait_done(1'b0, 60, n);
      n_checks++; if (n !== 42) $display("FAIL cont_period w%0d got %0d want 42", w, n); else n_pass++;
      n_checks++; if ($isunknown(bus.result) || bus.result < 15'd9 || bus.result > 15'd11)
        $display("FAIL cont_result w%0d got %0d want 10+-1", w, bus.result); else n_pass++;
    end
    repeat (5) @(negedge clk);
    bus.continuous = 1'b0;
    wait_done(1'b0, 60, n);
    n_checks++; if (n !== 37) $display("FAIL cont_last got %0d want 37", n); else n_pass++;
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL cont_stop_busy got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_abort();
    int dn = 0;
    pulse_start(1'b0, 16'd100);
    repeat (20) begin @(posedge clk); @(negedge clk); end
    bus.abort = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL abort_idle got busy=%b done=%b want 0/0", bus.busy, bus.done); else n_pass++;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    n_checks++; if (dn !== 0) $display("FAIL abort_no_done got %0d want 0", dn); else n_pass++;
    n_checks++; if ($isunknown(bus.result) || bus.result < 15'd9 || bus.result > 15'd11)
      $display("FAIL abort_bank_kept got %0d want 10+-1", bus.result); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first_n = 0;
    int dn = 0;
    pulse_start(1'b0, 16'd40);
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done === 1'b1) begin
        dn++;
        if (first_n == 0) first_n = k;
      end
      bus.start = (k == 10 || k == 20);
      if (k == 10) bus.gate_cycles = 16'd8;
    end
    bus.start = 1'b0;
    n_checks++; if (first_n !== 41) $display("FAIL ignore_start_latency got %0d want 41", first_n); else n_pass++;
    n_checks++; if (dn !== 1) $display("FAIL ignore_start_done_count got %0d want 1", dn); else n_pass++;
    n_checks++; if ($isunknown(bus.result) || bus.result < 15'd9 || bus.result > 15'd11)
      $display("FAIL ignore_start_result got %0d want 10+-1", bus.result); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_start(1'b0, 16'd100);
    repeat (30) begin @(posedge clk); @(negedge clk); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 15'd0)
      $display("FAIL midrst got busy=%b done=%b res=%0d want 0/0/0", bus.busy, bus.done, bus.result);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start(1'b0, 16'd40);
    wait_done(1'b0, 60, n);
    n_checks++; if (n !== 41) $display("FAIL postrst_latency got %0d want 41", n); else n_pass++;
    n_checks++; if ($isunknown(bus.result) || bus.result < 15'd9 || bus.result > 15'd11)
      $display("FAIL postrst_result got %0d want 10+-1", bus.result); else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.continuous = 1'b0;
    bus.gate_cycles = 16'd0;  bus.ch_sel = 2'd0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.continuous = 1'b0;
    bus4.gate_cycles = 16'd0; bus4.ch_sel = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_gate_zero();
    test_continuous();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
